// File: rtl/vga_csr_multi.sv
// APB register bank for a multi-window VGA overlay: shadow registers written over APB,
// copied atomically to the active (renderer-facing) set on the first frame_start after a commit request.
module vga_csr_multi #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WIN    = 4,
    parameter int COORD_W    = 10,
    parameter int COLOR_W    = 4
) (
    input  logic                         pclk,
    input  logic                         preset_n,
    input  logic                         psel,
    input  logic                         penable,
    input  logic                         pwrite,
    input  logic [ADDR_WIDTH-1:0]        paddr,
    input  logic [DATA_WIDTH-1:0]        pwdata,
    output logic [DATA_WIDTH-1:0]        prdata,
    output logic                         pready,
    output logic                         pslverr,
    input  logic                         frame_start,
    output logic [NUM_WIN*COORD_W-1:0]   win_x_start,
    output logic [NUM_WIN*COORD_W-1:0]   win_x_end,
    output logic [NUM_WIN*COORD_W-1:0]   win_y_start,
    output logic [NUM_WIN*COORD_W-1:0]   win_y_end,
    output logic [NUM_WIN*COLOR_W-1:0]   win_color,
    output logic [NUM_WIN-1:0]           win_en,
    output logic                         irq
);

    localparam int XY_W = 2 * COORD_W;
    localparam logic [4:0] NUM_WIN_U = 5'(NUM_WIN);
    localparam logic [ADDR_WIDTH-5:0] GLB_PAGE = (ADDR_WIDTH-4)'(16);

    // X/Y words are kept packed exactly as written: start in the upper half, end in the lower half
    logic [XY_W-1:0]    sh_x_q   [NUM_WIN];
    logic [XY_W-1:0]    sh_x_d   [NUM_WIN];
    logic [XY_W-1:0]    sh_y_q   [NUM_WIN];
    logic [XY_W-1:0]    sh_y_d   [NUM_WIN];
    logic [COLOR_W-1:0] sh_c_q   [NUM_WIN];
    logic [COLOR_W-1:0] sh_c_d   [NUM_WIN];
    logic [XY_W-1:0]    act_x_q  [NUM_WIN];
    logic [XY_W-1:0]    act_x_d  [NUM_WIN];
    logic [XY_W-1:0]    act_y_q  [NUM_WIN];
    logic [XY_W-1:0]    act_y_d  [NUM_WIN];
    logic [COLOR_W-1:0] act_c_q  [NUM_WIN];
    logic [COLOR_W-1:0] act_c_d  [NUM_WIN];

    logic [NUM_WIN-1:0]    sh_en_q, sh_en_d;
    logic [NUM_WIN-1:0]    act_en_q, act_en_d;
    logic                  pending_q, pending_d;
    logic [1:0]            int_stat_q, int_stat_d;
    logic [1:0]            int_en_q, int_en_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                  err_q, err_d;
    logic                  irq_q, irq_d;

    logic                  aligned;
    logic                  win_space;
    logic                  glb_space;
    logic                  idx_ok;
    logic                  win_hit;
    logic                  glb_hit;
    logic                  addr_ok;
    logic [3:0]            win_idx;
    logic [1:0]            reg_off;
    logic                  setup_ph;
    logic                  wr_en;
    logic                  commit_fire;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  unused_pwdata;

    assign unused_pwdata = ^pwdata;

    always_comb begin
        win_idx   = paddr[7:4];
        reg_off   = paddr[3:2];
        aligned   = (paddr[1:0] == 2'b00);
        win_space = (paddr[ADDR_WIDTH-1:8] == '0);
        glb_space = (paddr[ADDR_WIDTH-1:4] == GLB_PAGE);
        idx_ok    = ({1'b0, win_idx} < NUM_WIN_U);
        win_hit   = aligned & win_space & idx_ok & (reg_off != 2'd3);
        glb_hit   = aligned & glb_space;
        addr_ok   = win_hit | glb_hit;
    end

    assign setup_ph    = psel & ~penable;
    assign wr_en       = psel & penable & pwrite & addr_ok;
    assign commit_fire = frame_start & pending_q;

    always_comb begin
        rd_data = '0;
        if (win_hit) begin
            for (int n = 0; n < NUM_WIN; n++) begin
                if (win_idx == 4'(n)) begin
                    case (reg_off)
                        2'd0:    rd_data[XY_W-1:0]    = sh_x_q[n];
                        2'd1:    rd_data[XY_W-1:0]    = sh_y_q[n];
                        2'd2:    rd_data[COLOR_W-1:0] = sh_c_q[n];
                        default: rd_data              = '0;
                    endcase
                end
            end
        end else if (glb_hit) begin
            case (reg_off)
                2'd0:    rd_data[NUM_WIN-1:0] = sh_en_q;
                2'd1:    rd_data[0]           = pending_q;
                2'd2:    rd_data[1:0]         = int_stat_q;
                default: rd_data[1:0]         = int_en_q;
            endcase
        end
    end

    // The active set samples the shadows before this edge's write lands, so a
    // coincident write waits for the following commit
    always_comb begin
        for (int n = 0; n < NUM_WIN; n++) begin
            sh_x_d[n]  = sh_x_q[n];
            sh_y_d[n]  = sh_y_q[n];
            sh_c_d[n]  = sh_c_q[n];
            act_x_d[n] = commit_fire ? sh_x_q[n] : act_x_q[n];
            act_y_d[n] = commit_fire ? sh_y_q[n] : act_y_q[n];
            act_c_d[n] = commit_fire ? sh_c_q[n] : act_c_q[n];
        end
        sh_en_d  = sh_en_q;
        act_en_d = commit_fire ? sh_en_q : act_en_q;
        int_en_d = int_en_q;

        if (wr_en && win_hit) begin
            for (int n = 0; n < NUM_WIN; n++) begin
                if (win_idx == 4'(n)) begin
                    case (reg_off)
                        2'd0:    sh_x_d[n] = pwdata[XY_W-1:0];
                        2'd1:    sh_y_d[n] = pwdata[XY_W-1:0];
                        2'd2:    sh_c_d[n] = pwdata[COLOR_W-1:0];
                        default: sh_c_d[n] = sh_c_q[n];
                    endcase
                end
            end
        end
        if (wr_en && glb_hit && reg_off == 2'd0) begin
            sh_en_d = pwdata[NUM_WIN-1:0];
        end
        if (wr_en && glb_hit && reg_off == 2'd3) begin
            int_en_d = pwdata[1:0];
        end
    end

    // A commit request arriving with the committing frame re-arms pending;
    // hardware status sets override a coincident write-1-to-clear
    always_comb begin
        pending_d = pending_q;
        if (commit_fire) begin
            pending_d = 1'b0;
        end
        if (wr_en && glb_hit && reg_off == 2'd1 && pwdata[0]) begin
            pending_d = 1'b1;
        end

        int_stat_d = int_stat_q;
        if (wr_en && glb_hit && reg_off == 2'd2) begin
            int_stat_d = int_stat_q & ~pwdata[1:0];
        end
        if (frame_start) begin
            int_stat_d[0] = 1'b1;
        end
        if (commit_fire) begin
            int_stat_d[1] = 1'b1;
        end

        irq_d = |(int_stat_q & int_en_q);
    end

    always_comb begin
        prdata_d = prdata_q;
        err_d    = err_q;
        if (setup_ph) begin
            err_d = ~addr_ok;
            if (!pwrite) begin
                prdata_d = rd_data;
            end
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            for (int n = 0; n < NUM_WIN; n++) begin
                sh_x_q[n]  <= '0;
                sh_y_q[n]  <= '0;
                sh_c_q[n]  <= '0;
                act_x_q[n] <= '0;
                act_y_q[n] <= '0;
                act_c_q[n] <= '0;
            end
            sh_en_q    <= '0;
            act_en_q   <= '0;
            pending_q  <= 1'b0;
            int_stat_q <= '0;
            int_en_q   <= '0;
            prdata_q   <= '0;
            err_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            for (int n = 0; n < NUM_WIN; n++) begin
                sh_x_q[n]  <= sh_x_d[n];
                sh_y_q[n]  <= sh_y_d[n];
                sh_c_q[n]  <= sh_c_d[n];
                act_x_q[n] <= act_x_d[n];
                act_y_q[n] <= act_y_d[n];
                act_c_q[n] <= act_c_d[n];
            end
            sh_en_q    <= sh_en_d;
            act_en_q   <= act_en_d;
            pending_q  <= pending_d;
            int_stat_q <= int_stat_d;
            int_en_q   <= int_en_d;
            prdata_q   <= prdata_d;
            err_q      <= err_d;
            irq_q      <= irq_d;
        end
    end

    for (genvar g = 0; g < NUM_WIN; g++) begin : g_out
        assign win_x_start[g*COORD_W +: COORD_W] = act_x_q[g][XY_W-1:COORD_W];
        assign win_x_end[g*COORD_W +: COORD_W]   = act_x_q[g][COORD_W-1:0];
        assign win_y_start[g*COORD_W +: COORD_W] = act_y_q[g][XY_W-1:COORD_W];
        assign win_y_end[g*COORD_W +: COORD_W]   = act_y_q[g][COORD_W-1:0];
        assign win_color[g*COLOR_W +: COLOR_W]   = act_c_q[g];
    end

    assign win_en  = act_en_q;
    assign irq     = irq_q;
    assign prdata  = prdata_q;
    assign pready  = 1'b1;
    assign pslverr = err_q & psel & penable;

endmodule

// File: tb/tb_vga_csr_multi.sv
// Directed bench for vga_csr_multi: a register-level reference model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_vga_csr_multi;

    localparam int ADDR_WIDTH = 12;
    localparam int DATA_WIDTH = 32;
    localparam int NUM_WIN    = 4;
    localparam int COORD_W    = 10;
    localparam int COLOR_W    = 4;

    logic                        pclk;
    logic                        preset_n;
    logic                        psel;
    logic                        penable;
    logic                        pwrite;
    logic [ADDR_WIDTH-1:0]       paddr;
    logic [DATA_WIDTH-1:0]       pwdata;
    logic [DATA_WIDTH-1:0]       prdata;
    logic                        pready;
    logic                        pslverr;
    logic                        frame_start;
    logic [NUM_WIN*COORD_W-1:0]  win_x_start;
    logic [NUM_WIN*COORD_W-1:0]  win_x_end;
    logic [NUM_WIN*COORD_W-1:0]  win_y_start;
    logic [NUM_WIN*COORD_W-1:0]  win_y_end;
    logic [NUM_WIN*COLOR_W-1:0]  win_color;
    logic [NUM_WIN-1:0]          win_en;
    logic                        irq;

    vga_csr_multi #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_WIN(NUM_WIN),
        .COORD_W(COORD_W),
        .COLOR_W(COLOR_W)
    ) dut (
        .pclk(pclk),
        .preset_n(preset_n),
        .psel(psel),
        .penable(penable),
        .pwrite(pwrite),
        .paddr(paddr),
        .pwdata(pwdata),
        .prdata(prdata),
        .pready(pready),
        .pslverr(pslverr),
        .frame_start(frame_start),
        .win_x_start(win_x_start),
        .win_x_end(win_x_end),
        .win_y_start(win_y_start),
        .win_y_end(win_y_end),
        .win_color(win_color),
        .win_en(win_en),
        .irq(irq)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int vec_count   = 0;
    int miscompares = 0;
    bit check_en    = 1'b0;

    // Reference model: register contents as plain integers, updated once per clock edge
    int unsigned m_shx [NUM_WIN];
    int unsigned m_shy [NUM_WIN];
    int unsigned m_shc [NUM_WIN];
    int unsigned m_acx [NUM_WIN];
    int unsigned m_acy [NUM_WIN];
    int unsigned m_acc [NUM_WIN];
    int unsigned m_shen, m_acen, m_pend, m_stat, m_inten;
    bit          m_irq, m_wr, m_fire;

    logic [NUM_WIN*COORD_W-1:0] e_xs, e_xe, e_ys, e_ye;
    logic [NUM_WIN*COLOR_W-1:0] e_col;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ok(input logic [ADDR_WIDTH-1:0] a);
        if (a[1:0] != 2'b00) return 1'b0;
        if (a < 12'h100) return ((a >> 4) < NUM_WIN) && ((a & 12'hC) != 12'hC);
        return (a <= 12'h10C);
    endfunction

    function automatic logic [31:0] model_read(input logic [ADDR_WIDTH-1:0] a);
        int n;
        if (!model_ok(a)) return 32'h0;
        if (a < 12'h100) begin
            n = int'(a >> 4);
            case (a & 12'hC)
                12'h0:   return m_shx[n];
                12'h4:   return m_shy[n];
                default: return m_shc[n];
            endcase
        end
        case (a)
            12'h100: return m_shen;
            12'h104: return m_pend;
            12'h108: return m_stat;
            default: return m_inten;
        endcase
    endfunction

    always @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            for (int n = 0; n < NUM_WIN; n++) begin
                m_shx[n] = 0; m_shy[n] = 0; m_shc[n] = 0;
                m_acx[n] = 0; m_acy[n] = 0; m_acc[n] = 0;
            end
            m_shen = 0; m_acen = 0; m_pend = 0; m_stat = 0; m_inten = 0; m_irq = 0;
        end else begin
            m_wr   = psel && penable && pwrite && model_ok(paddr);
            m_fire = frame_start && (m_pend != 0);
            m_irq  = ((m_stat & m_inten) != 0);
            if (m_fire) begin
                m_acx = m_shx; m_acy = m_shy; m_acc = m_shc; m_acen = m_shen;
                m_pend = 0;
            end
            if (m_wr && paddr == 12'h108) m_stat = m_stat & ~(pwdata & 32'h3);
            if (frame_start) m_stat = m_stat | 1;
            if (m_fire) m_stat = m_stat | 2;
            if (m_wr) begin
                if (paddr < 12'h100) begin
                    case (paddr & 12'hC)
                        12'h0:   m_shx[paddr >> 4] = pwdata & 32'hFFFFF;
                        12'h4:   m_shy[paddr >> 4] = pwdata & 32'hFFFFF;
                        default: m_shc[paddr >> 4] = pwdata & 32'hF;
                    endcase
                end else begin
                    case (paddr)
                        12'h100: m_shen = pwdata & 32'hF;
                        12'h104: if (pwdata[0]) m_pend = 1;
                        12'h10C: m_inten = pwdata & 32'h3;
                        default: ;
                    endcase
                end
            end
        end
    end

    always @(negedge pclk) begin
        if (check_en && preset_n) begin
            for (int n = 0; n < NUM_WIN; n++) begin
                e_xs[n*COORD_W +: COORD_W]  = 10'(m_acx[n] >> 10);
                e_xe[n*COORD_W +: COORD_W]  = 10'(m_acx[n] & 32'h3FF);
                e_ys[n*COORD_W +: COORD_W]  = 10'(m_acy[n] >> 10);
                e_ye[n*COORD_W +: COORD_W]  = 10'(m_acy[n] & 32'h3FF);
                e_col[n*COLOR_W +: COLOR_W] = 4'(m_acc[n]);
            end
            checkOutput("win_x_start", 64'(win_x_start), 64'(e_xs));
            checkOutput("win_x_end",   64'(win_x_end),   64'(e_xe));
            checkOutput("win_y_start", 64'(win_y_start), 64'(e_ys));
            checkOutput("win_y_end",   64'(win_y_end),   64'(e_ye));
            checkOutput("win_color",   64'(win_color),   64'(e_col));
            checkOutput("win_en",      64'(win_en),      64'(m_acen));
            checkOutput("irq",         64'(irq),         64'(m_irq));
            checkOutput("pready",      64'(pready),      64'd1);
        end
    end

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d, input bit fs, input bit exp_err);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge pclk);
        penable = 1'b1; frame_start = fs;
        #1 checkOutput("wr_pslverr", 64'(pslverr), 64'(exp_err));
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; frame_start = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, input bit exp_err, output logic [31:0] d);
        logic [31:0] exp_d;
        exp_d = model_read(a);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(negedge pclk);
        penable = 1'b1;
        #1;
        d = prdata;
        checkOutput("rd_pslverr", 64'(pslverr), 64'(exp_err));
        checkOutput("rd_model", 64'(prdata), 64'(exp_d));
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        @(negedge pclk);
        frame_start = 1'b0;
    endtask

    task automatic applyStimulus();
        logic [31:0] rd;

        // Reset values
        psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; frame_start = 0;
        preset_n = 1'b0;
        repeat (3) @(negedge pclk);
        checkOutput("rst_x_start", 64'(win_x_start), 64'd0);
        checkOutput("rst_color",   64'(win_color),   64'd0);
        checkOutput("rst_irq",     64'(irq),         64'd0);
        preset_n = 1'b1;
        check_en = 1'b1;
        @(negedge pclk);
        apb_read(12'h000, 1'b0, rd); checkOutput("rst_rd_000", 64'(rd), 64'd0);
        apb_read(12'h104, 1'b0, rd); checkOutput("rst_rd_104", 64'(rd), 64'd0);
        apb_read(12'h108, 1'b0, rd); checkOutput("rst_rd_108", 64'(rd), 64'd0);

        // Shadow write, then commit on frame_start
        apb_write(12'h010, 32'h0A0C8, 1'b0, 1'b0);
        apb_read(12'h010, 1'b0, rd); checkOutput("rd_x1", 64'(rd), 64'h0A0C8);
        checkOutput("xs1_precommit", 64'(win_x_start[19:10]), 64'd0);
        apb_write(12'h104, 32'h1, 1'b0, 1'b0);
        apb_read(12'h104, 1'b0, rd); checkOutput("pending_set", 64'(rd), 64'd1);
        pulse_frame();
        #1;
        checkOutput("xs1_commit", 64'(win_x_start[19:10]), 64'h028);
        checkOutput("xe1_commit", 64'(win_x_end[19:10]),   64'h0C8);
        apb_read(12'h104, 1'b0, rd); checkOutput("pending_clr", 64'(rd), 64'd0);
        apb_read(12'h108, 1'b0, rd); checkOutput("int_stat_3", 64'(rd), 64'd3);

        // Interrupt timing and W1C
        apb_write(12'h108, 32'h3, 1'b0, 1'b0);
        apb_write(12'h10C, 32'h2, 1'b0, 1'b0);
        apb_write(12'h104, 32'h1, 1'b0, 1'b0);
        pulse_frame();
        checkOutput("irq_lag", 64'(irq), 64'd0);
        @(negedge pclk);
        checkOutput("irq_set", 64'(irq), 64'd1);
        apb_write(12'h108, 32'h2, 1'b0, 1'b0);
        checkOutput("irq_hold", 64'(irq), 64'd1);
        @(negedge pclk);
        checkOutput("irq_clr", 64'(irq), 64'd0);
        apb_write(12'h108, 32'h1, 1'b1, 1'b0);
        apb_read(12'h108, 1'b0, rd); checkOutput("w1c_vs_set", 64'(rd), 64'd1);

        // Unmapped accesses
        apb_write(12'h040, 32'hFFFFF, 1'b0, 1'b1);
        apb_read(12'h040, 1'b1, rd); checkOutput("rd_040", 64'(rd), 64'd0);
        apb_write(12'h0FC, 32'hFFFFF, 1'b0, 1'b1);
        apb_read(12'h0FC, 1'b1, rd); checkOutput("rd_0fc", 64'(rd), 64'd0);
        apb_write(12'h00C, 32'hFFFF, 1'b0, 1'b1);
        apb_write(12'h105, 32'h1, 1'b0, 1'b1);
        apb_read(12'h101, 1'b1, rd);
        apb_read(12'h10C, 1'b0, rd); checkOutput("rd_10c", 64'(rd), 64'd2);
        apb_read(12'h000, 1'b0, rd); checkOutput("rd_000_untouched", 64'(rd), 64'd0);
        apb_read(12'h104, 1'b0, rd); checkOutput("pending_untouched", 64'(rd), 64'd0);

        // Shadow write colliding with a committing frame
        apb_write(12'h008, 32'h3, 1'b0, 1'b0);
        apb_write(12'h104, 32'h1, 1'b0, 1'b0);
        pulse_frame();
        #1 checkOutput("col0_first", 64'(win_color[3:0]), 64'd3);
        apb_write(12'h104, 32'h1, 1'b0, 1'b0);
        apb_write(12'h008, 32'h5, 1'b1, 1'b0);
        #1 checkOutput("col0_old", 64'(win_color[3:0]), 64'd3);
        apb_read(12'h104, 1'b0, rd); checkOutput("pending_after_collide", 64'(rd), 64'd0);
        apb_write(12'h104, 32'h1, 1'b0, 1'b0);
        pulse_frame();
        #1 checkOutput("col0_new", 64'(win_color[3:0]), 64'd5);

        // COMMIT write coinciding with frame_start
        apb_write(12'h104, 32'h1, 1'b0, 1'b0);
        apb_write(12'h104, 32'h1, 1'b1, 1'b0);
        apb_read(12'h104, 1'b0, rd); checkOutput("pending_rearm", 64'(rd), 64'd1);
        pulse_frame();
        apb_write(12'h000, 32'h00403, 1'b0, 1'b0);
        apb_write(12'h104, 32'h1, 1'b1, 1'b0);
        #1 checkOutput("xs0_no_commit", 64'(win_x_start[9:0]), 64'd0);
        apb_read(12'h104, 1'b0, rd); checkOutput("pending_late", 64'(rd), 64'd1);
        apb_write(12'h100, 32'h5, 1'b0, 1'b0);
        pulse_frame();
        #1;
        checkOutput("xs0_commit", 64'(win_x_start[9:0]), 64'd1);
        checkOutput("xe0_commit", 64'(win_x_end[9:0]),   64'd3);
        checkOutput("en_commit",  64'(win_en),           64'h5);

        // Asynchronous reset in the middle of a write access phase
        apb_write(12'h104, 32'h1, 1'b0, 1'b0);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h000; pwdata = 32'hFFFFF;
        @(negedge pclk);
        penable = 1'b1;
        #2 preset_n = 1'b0;
        #1;
        checkOutput("arst_x_start", 64'(win_x_start), 64'd0);
        checkOutput("arst_x_end",   64'(win_x_end),   64'd0);
        checkOutput("arst_color",   64'(win_color),   64'd0);
        checkOutput("arst_en",      64'(win_en),      64'd0);
        checkOutput("arst_irq",     64'(irq),         64'd0);
        checkOutput("arst_pslverr", 64'(pslverr),     64'd0);
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(negedge pclk);
        preset_n = 1'b1;
        @(negedge pclk);
        apb_read(12'h104, 1'b0, rd); checkOutput("arst_pending", 64'(rd), 64'd0);
        apb_read(12'h000, 1'b0, rd); checkOutput("arst_no_write", 64'(rd), 64'd0);
        repeat (2) @(negedge pclk);
    endtask

    initial begin
        applyStimulus();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete, got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
